// File: rtl/wb_queue.sv
// Pending register-write queue: buffers {addr, data} writes, drains them to the
// register file in arrival order when it is not stalled, and forwards the
// newest pending value for two read ports.
module wb_queue #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      flush,
  input  logic                      rf_stall,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic [ADDR_W-1:0]         fwd_addr_a,
  input  logic [ADDR_W-1:0]         fwd_addr_b,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b,
  output logic [DATA_W-1:0]         fwd_data_a,
  output logic [DATA_W-1:0]         fwd_data_b,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [AW-1:0]     head_q, tail_q;
  logic [CW-1:0]     cnt_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic              push, store, pop;
  logic [AW-1:0]     fidx;

  // Full only when every slot is occupied; flush blocks new requests.
  assign in_ready = (cnt_q != CW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  // Writes to r0 complete the handshake but are never stored.
  assign store    = push && (in_addr != '0);
  assign pop      = (cnt_q != '0) && !rf_stall && !flush;

  assign count    = cnt_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Entry storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (store) begin
      addr_mem[tail_q] <= in_addr;
      data_mem[tail_q] <= in_data;
    end
  end

  // Pointers, occupancy and the registered register-file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= pop;
      if (pop) begin
        rf_waddr_q <= addr_mem[head_q];
        rf_wdata_q <= data_mem[head_q];
      end
      if (flush) begin
        cnt_q  <= '0;
        head_q <= tail_q;
      end else begin
        if (store) tail_q <= tail_q + 1'b1;
        if (pop)   head_q <= head_q + 1'b1;
        cnt_q <= cnt_q + CW'(store) - CW'(pop);
      end
    end
  end

  // Forwarding: the in-flight rf write is the oldest candidate, then queue
  // entries oldest to newest so the newest matching entry wins.
  always_comb begin
    fidx       = '0;
    fwd_hit_a  = rf_we_q && (rf_waddr_q == fwd_addr_a);
    fwd_data_a = fwd_hit_a ? rf_wdata_q : '0;
    fwd_hit_b  = rf_we_q && (rf_waddr_q == fwd_addr_b);
    fwd_data_b = fwd_hit_b ? rf_wdata_q : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(cnt_q)) begin
        fidx = head_q + AW'(i);
        if (addr_mem[fidx] == fwd_addr_a) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = data_mem[fidx];
        end
        if (addr_mem[fidx] == fwd_addr_b) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = data_mem[fidx];
        end
      end
    end
    if (fwd_addr_a == '0) begin
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
    end
    if (fwd_addr_b == '0) begin
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a vector table for single-cycle behaviour plus
// hand-written sequences for stall/full, reset mid-drain and pointer wrap.
module tb_wb_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, rf_stall, rf_we;
  logic [5:0]  in_addr, rf_waddr, fwd_addr_a, fwd_addr_b;
  logic [31:0] in_data, rf_wdata, fwd_data_a, fwd_data_b;
  logic        fwd_hit_a, fwd_hit_b;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  wb_queue #(.ADDR_W(6), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .flush(flush), .rf_stall(rf_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  a;
    logic [31:0] d;
    logic        fl;
    logic        st;
    logic [5:0]  fa;
    logic [5:0]  fb;
    logic        rdy;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        ha;
    logic [31:0] da;
    logic        hb;
    logic [31:0] db;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic [31:0] d,
                       input logic fl, input logic st);
    in_valid = v; in_addr = a; in_data = d; flush = fl; rf_stall = st;
  endtask

  initial begin
    logic [31:0] expd [$];
    logic [5:0]  expa [$];
    logic [31:0] ed;
    logic [5:0]  ea;
    int          writes;

    rst = 1'b1;
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    fwd_addr_a = 6'd0; fwd_addr_b = 6'd0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);

    //         v     a      d              fl    st    fa     fb      rdy   we    wa     wd             cnt   ha    da             hb    db
    tv[0] = '{1'b1, 6'd5, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd5, 6'd0,  1'b1, 1'b0, 6'd0, 32'h0,        3'd1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0};
    tv[1] = '{1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 6'd5, 6'd0,  1'b1, 1'b1, 6'd5, 32'hA5A5A5A5, 3'd0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0};
    tv[2] = '{1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 6'd5, 6'd0,  1'b1, 1'b0, 6'd5, 32'hA5A5A5A5, 3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[3] = '{1'b1, 6'd0, 32'h77,       1'b0, 1'b0, 6'd0, 6'd5,  1'b1, 1'b0, 6'd5, 32'hA5A5A5A5, 3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[4] = '{1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 6'd0, 6'd0,  1'b1, 1'b0, 6'd5, 32'hA5A5A5A5, 3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[5] = '{1'b1, 6'd7, 32'h11,       1'b0, 1'b1, 6'd7, 6'd0,  1'b1, 1'b0, 6'd5, 32'hA5A5A5A5, 3'd1, 1'b1, 32'h11,       1'b0, 32'h0};
    tv[6] = '{1'b1, 6'd7, 32'h22,       1'b0, 1'b1, 6'd7, 6'd0,  1'b1, 1'b0, 6'd5, 32'hA5A5A5A5, 3'd2, 1'b1, 32'h22,       1'b0, 32'h0};
    tv[7] = '{1'b1, 6'd3, 32'h33,       1'b0, 1'b1, 6'd3, 6'd7,  1'b1, 1'b0, 6'd5, 32'hA5A5A5A5, 3'd3, 1'b1, 32'h33,       1'b1, 32'h22};
    tv[8] = '{1'b1, 6'd9, 32'h99,       1'b1, 1'b0, 6'd9, 6'd7,  1'b0, 1'b0, 6'd5, 32'hA5A5A5A5, 3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[9] = '{1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 6'd9, 6'd7,  1'b1, 1'b0, 6'd5, 32'hA5A5A5A5, 3'd0, 1'b0, 32'h0,        1'b0, 32'h0};

    for (int k = 0; k < 10; k++) begin
      drive(tv[k].v, tv[k].a, tv[k].d, tv[k].fl, tv[k].st);
      fwd_addr_a = tv[k].fa; fwd_addr_b = tv[k].fb;
      step();
      chk($sformatf("v%0d_ready", k), 32'(in_ready), 32'(tv[k].rdy));
      chk($sformatf("v%0d_we", k), 32'(rf_we), 32'(tv[k].we));
      chk($sformatf("v%0d_waddr", k), 32'(rf_waddr), 32'(tv[k].wa));
      chk($sformatf("v%0d_wdata", k), rf_wdata, tv[k].wd);
      chk($sformatf("v%0d_count", k), 32'(count), 32'(tv[k].cnt));
      chk($sformatf("v%0d_hit_a", k), 32'(fwd_hit_a), 32'(tv[k].ha));
      chk($sformatf("v%0d_data_a", k), fwd_data_a, tv[k].da);
      chk($sformatf("v%0d_hit_b", k), 32'(fwd_hit_b), 32'(tv[k].hb));
      chk($sformatf("v%0d_data_b", k), fwd_data_b, tv[k].db);
    end

    // Fill under stall, refuse a fifth push, then drain back-to-back.
    fwd_addr_a = 6'd0; fwd_addr_b = 6'd0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 6'(i), 32'h100 + 32'(i), 1'b0, 1'b1);
      step();
      chk("fill_we", 32'(rf_we), 32'd0);
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 6'd5, 32'h105, 1'b0, 1'b1);
    step();
    chk("full_hold_count", 32'(count), 32'd4);
    fwd_addr_a = 6'd5;
    #0;
    chk("full_no_5th", 32'(fwd_hit_a), 32'd0);
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("drain_we", 32'(rf_we), 32'd1);
      chk("drain_waddr", 32'(rf_waddr), 32'(i));
      chk("drain_wdata", rf_wdata, 32'h100 + 32'(i));
      chk("drain_count", 32'(count), 32'(4 - i));
    end
    step();
    chk("drain_end_we", 32'(rf_we), 32'd0);

    // Reset asserted while a write pulse is on the rf port.
    drive(1'b1, 6'd2, 32'h55, 1'b0, 1'b1);
    step();
    drive(1'b1, 6'd4, 32'h66, 1'b0, 1'b1);
    step();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    step();
    chk("pre_rst_we", 32'(rf_we), 32'd1);
    chk("pre_rst_waddr", 32'(rf_waddr), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_we", 32'(rf_we), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_waddr", 32'(rf_waddr), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_we", 32'(rf_we), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Continuous push+pop across pointer wrap: order and occupancy preserved.
    writes = 0;
    for (int i = 0; i <= 2 * DEPTH + 1; i++) begin
      if (i <= 2 * DEPTH) begin
        drive(1'b1, 6'(1 + i % 7), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        expa.push_back(6'(1 + i % 7));
        expd.push_back(32'hC000_0000 + 32'(i));
      end else begin
        drive(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
      end
      step();
      chk("wrap_count", 32'(count), (i <= 2 * DEPTH) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk("wrap_we", 32'(rf_we), 32'd1);
        if (rf_we === 1'b1 && expd.size() > 0) begin
          ea = expa.pop_front();
          ed = expd.pop_front();
          writes++;
          chk("wrap_waddr", 32'(rf_waddr), 32'(ea));
          chk("wrap_wdata", rf_wdata, ed);
        end
      end
    end
    step();
    chk("wrap_no_dup", 32'(rf_we), 32'd0);
    chk("wrap_writes", 32'(writes), 32'(2 * DEPTH + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
